// File: rtl/rcu_clkdiv_pkg.sv
// Types and constants shared by the RCU clock divider top and its channel slice.
`include "rcu_define.sv"

package rcu_clkdiv_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = `RCU_CLKDIV_STATE_OFF,
        ST_RUN  = `RCU_CLKDIV_STATE_RUN,
        ST_STOP = `RCU_CLKDIV_STATE_STOP
    } chan_state_e;

    localparam int unsigned DIV_MIN = `RCU_CLKDIV_DIV_MIN;

endpackage

// File: rtl/rcu_clkdiv_chan.sv
// One divider channel: period counter, run/stop FSM, pending-ratio register, flopped outputs.
//
//   state | meaning
//   OFF   | idle, counter held at 0, divided clock low
//   RUN   | counting, en_i high
//   STOP  | en_i dropped, finishing the current period before OFF
module rcu_clkdiv_chan
    import rcu_clkdiv_pkg::*;
#(
    parameter int unsigned DIV_WIDTH = 8,
    parameter int unsigned DIV_RST   = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 en_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic                 upd_req_i,
    output logic                 upd_ack_o,
    output logic                 div_clk_o,
    output logic                 clk_en_o,
    output logic                 busy_o
);

    localparam logic [DIV_WIDTH-1:0] R_RST = DIV_WIDTH'(DIV_RST);
    localparam logic [DIV_WIDTH-1:0] R_MIN = DIV_WIDTH'(DIV_MIN);
    localparam logic [DIV_WIDTH-1:0] ONE   = DIV_WIDTH'(1);

    chan_state_e          state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] r_q, r_d;
    logic [DIV_WIDTH-1:0] pend_q, pend_d;
    logic                 pend_vld_q, pend_vld_d;
    logic                 div_clk_q, div_clk_d;
    logic                 clk_en_q, clk_en_d;
    logic                 ack_q, ack_d;
    logic                 busy_q, busy_d;
    logic                 wrap, load, wrap_nxt;

    assign wrap = (state_q != ST_OFF) && (cnt_q == r_q - ONE);
    assign load = pend_vld_q && ((state_q == ST_OFF) || wrap);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_OFF;
            cnt_q      <= '0;
            r_q        <= R_RST;
            pend_q     <= R_RST;
            pend_vld_q <= 1'b0;
            div_clk_q  <= 1'b0;
            clk_en_q   <= 1'b0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            r_q        <= r_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            div_clk_q  <= div_clk_d;
            clk_en_q   <= clk_en_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
        end
    end

    // A wrap consumes the pend present before this cycle's request; a new request re-arms pend.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        r_d        = r_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        if (load) begin
            r_d        = pend_q;
            pend_vld_d = 1'b0;
        end
        if (upd_req_i) begin
            pend_d     = (div_i < R_MIN) ? R_MIN : div_i;
            pend_vld_d = 1'b1;
        end
        unique case (state_q)
            ST_OFF: begin
                cnt_d = '0;
                if (en_i) state_d = ST_RUN;
            end
            ST_RUN: begin
                cnt_d = wrap ? '0 : cnt_q + ONE;
                if (!en_i) state_d = ST_STOP;
            end
            ST_STOP: begin
                cnt_d = wrap ? '0 : cnt_q + ONE;
                if (en_i)      state_d = ST_RUN;
                else if (wrap) state_d = ST_OFF;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_OFF;
            end
        endcase
    end

    // Outputs are derived from next-state values so each flop shows the condition of its own cycle.
    always_comb begin
        wrap_nxt  = (state_d != ST_OFF) && (cnt_d == r_d - ONE);
        div_clk_d = (state_d != ST_OFF) && (cnt_d < (r_d >> 1));
        clk_en_d  = wrap_nxt;
        ack_d     = pend_vld_d && ((state_d == ST_OFF) || wrap_nxt);
        busy_d    = (state_d != ST_OFF);
    end

    assign upd_ack_o = ack_q;
    assign div_clk_o = div_clk_q;
    assign clk_en_o  = clk_en_q;
    assign busy_o    = busy_q;

endmodule

// File: rtl/rcu_define.sv
// Shared RCU clock-divider constants: per-channel state encodings and minimum divide ratio.
`ifndef RCU_DEFINE_SV
`define RCU_DEFINE_SV

`define RCU_CLKDIV_STATE_OFF  2'd0
`define RCU_CLKDIV_STATE_RUN  2'd1
`define RCU_CLKDIV_STATE_STOP 2'd2

`define RCU_CLKDIV_DIV_MIN    2

`endif

// File: rtl/rcu_clkdiv.sv
// Multi-channel programmable clock divider: one independent divider slice per channel.
module rcu_clkdiv #(
    parameter int unsigned CHAN_NUM  = 4,
    parameter int unsigned DIV_WIDTH = 8,
    parameter int unsigned DIV_RST   = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [CHAN_NUM-1:0]           en_i,
    input  logic [CHAN_NUM*DIV_WIDTH-1:0] div_i,
    input  logic [CHAN_NUM-1:0]           upd_req_i,
    output logic [CHAN_NUM-1:0]           upd_ack_o,
    output logic [CHAN_NUM-1:0]           div_clk_o,
    output logic [CHAN_NUM-1:0]           clk_en_o,
    output logic [CHAN_NUM-1:0]           busy_o
);

    for (genvar k = 0; k < CHAN_NUM; k++) begin : g_chan
        rcu_clkdiv_chan #(
            .DIV_WIDTH (DIV_WIDTH),
            .DIV_RST   (DIV_RST)
        ) u_chan (
            .clk_i     (clk_i),
            .rst_n_i   (rst_n_i),
            .en_i      (en_i[k]),
            .div_i     (div_i[k*DIV_WIDTH +: DIV_WIDTH]),
            .upd_req_i (upd_req_i[k]),
            .upd_ack_o (upd_ack_o[k]),
            .div_clk_o (div_clk_o[k]),
            .clk_en_o  (clk_en_o[k]),
            .busy_o    (busy_o[k])
        );
    end

endmodule

// File: tb/tb_rcu_clkdiv.sv
// Bench for rcu_clkdiv: per-cycle behavioural model comparison plus directed literal checks.
module tb_rcu_clkdiv;

    localparam int CH  = 4;
    localparam int DW  = 8;
    localparam int RST = 2;

    logic          clk_i = 1'b0;
    logic          rst_n_i = 1'b1;
    logic [CH-1:0] en_i = '0;
    logic [CH*DW-1:0] div_i = '0;
    logic [CH-1:0] upd_req_i = '0;
    logic [CH-1:0] upd_ack_o, div_clk_o, clk_en_o, busy_o;

    int n_chk = 0;
    int n_err = 0;

    rcu_clkdiv #(.CHAN_NUM(CH), .DIV_WIDTH(DW), .DIV_RST(RST)) dut (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .en_i      (en_i),
        .div_i     (div_i),
        .upd_req_i (upd_req_i),
        .upd_ack_o (upd_ack_o),
        .div_clk_o (div_clk_o),
        .clk_en_o  (clk_en_o),
        .busy_o    (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: each channel is a period of 'ratio' cycles at position 'phase'.
    int ratio [CH];
    int pend  [CH];
    bit pv    [CH];
    int phase [CH];
    bit active[CH];
    bit stopping[CH];

    function automatic int clamp(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    function automatic bit m_last(input int k);
        return active[k] && (phase[k] == ratio[k] - 1);
    endfunction

    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < CH; k++) begin
                ratio[k] <= RST; pend[k] <= RST; pv[k] <= 1'b0;
                phase[k] <= 0;   active[k] <= 1'b0; stopping[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < CH; k++) begin
                if (pv[k] && (!active[k] || m_last(k))) begin
                    ratio[k] <= pend[k];
                    pv[k]    <= 1'b0;
                end
                if (upd_req_i[k]) begin
                    pend[k] <= clamp(int'(div_i[k*DW +: DW]));
                    pv[k]   <= 1'b1;
                end
                if (!active[k]) begin
                    if (en_i[k]) begin
                        active[k] <= 1'b1; stopping[k] <= 1'b0; phase[k] <= 0;
                    end
                end else begin
                    phase[k] <= m_last(k) ? 0 : phase[k] + 1;
                    if (en_i[k])           stopping[k] <= 1'b0;
                    else if (!stopping[k]) stopping[k] <= 1'b1;
                    else if (m_last(k)) begin
                        active[k] <= 1'b0; phase[k] <= 0;
                    end
                end
            end
        end
    end

    always @(negedge clk_i) begin
        logic [CH-1:0] e_div, e_ce, e_ack, e_busy;
        for (int k = 0; k < CH; k++) begin
            e_div[k]  = active[k] && (phase[k] < ratio[k] / 2);
            e_ce[k]   = m_last(k);
            e_ack[k]  = pv[k] && (!active[k] || m_last(k));
            e_busy[k] = active[k];
        end
        chk("mdl_div_clk", 32'(div_clk_o), 32'(e_div));
        chk("mdl_clk_en",  32'(clk_en_o),  32'(e_ce));
        chk("mdl_upd_ack", 32'(upd_ack_o), 32'(e_ack));
        chk("mdl_busy",    32'(busy_o),    32'(e_busy));
    end

    task automatic req(input int k, input int d);
        div_i[k*DW +: DW] = DW'(d);
        upd_req_i[k]      = 1'b1;
    endtask

    task automatic wait_ce(input int k, input int budget);
        int n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!clk_en_o[k] && n < budget);
        chk("wait_clk_en", 32'(clk_en_o[k]), 32'd1);
    endtask

    int t2_div[10] = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 0};
    int t2_ce [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int t4_div[4]  = '{0, 0, 0, 0};
    int t4_ce [4]  = '{0, 0, 1, 0};
    int t4_bsy[4]  = '{1, 1, 1, 0};
    int t4b_div[7] = '{0, 1, 1, 1, 0, 0, 0};
    int t4b_ce [7] = '{1, 0, 0, 0, 0, 0, 1};

    initial begin
        int acks;
        int n;
        #1 rst_n_i = 1'b0;
        en_i[0] = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("reset_outputs", 32'({upd_ack_o, div_clk_o, clk_en_o, busy_o}), 32'd0);
        rst_n_i = 1'b1;

        // 1: channel 0 at reset ratio 2
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("t1_div_clk", 32'(div_clk_o[0]), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("t1_clk_en",  32'(clk_en_o[0]),  (i % 2 == 1) ? 32'd1 : 32'd0);
            chk("t1_busy",    32'(busy_o[0]),    32'd1);
        end

        // 2: channel 1 at 4, switch to 5 mid-period
        @(negedge clk_i); req(1, 4);
        @(negedge clk_i); upd_req_i = '0;
        chk("t2_ack_off", 32'(upd_ack_o[1]), 32'd1);
        en_i[1] = 1'b1;
        wait_ce(1, 20);
        @(negedge clk_i);
        @(negedge clk_i); req(1, 5);
        @(negedge clk_i); upd_req_i = '0;
        chk("t2_cnt2_div", 32'(div_clk_o[1]), 32'd0);
        chk("t2_cnt2_ack", 32'(upd_ack_o[1]), 32'd0);
        @(negedge clk_i);
        chk("t2_wrap_ce",  32'(clk_en_o[1]),  32'd1);
        chk("t2_wrap_ack", 32'(upd_ack_o[1]), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            chk("t2_r5_div", 32'(div_clk_o[1]), 32'(t2_div[i]));
            chk("t2_r5_ce",  32'(clk_en_o[1]),  32'(t2_ce[i]));
        end

        // 3: clamp of 0 and 1 while OFF
        @(negedge clk_i); req(2, 0);
        @(negedge clk_i); req(2, 1);
        chk("t3_ack_div0", 32'(upd_ack_o[2]), 32'd1);
        @(negedge clk_i); upd_req_i = '0;
        chk("t3_ack_div1", 32'(upd_ack_o[2]), 32'd1);
        en_i[2] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("t3_div_clk", 32'(div_clk_o[2]), (i % 2 == 0) ? 32'd1 : 32'd0);
        end

        // 4: graceful stop at ratio 6, then stop cancelled
        @(negedge clk_i); req(3, 6);
        @(negedge clk_i); upd_req_i = '0; en_i[3] = 1'b1;
        wait_ce(3, 20);
        repeat (3) @(negedge clk_i);
        en_i[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("t4_stop_div",  32'(div_clk_o[3]), 32'(t4_div[i]));
            chk("t4_stop_ce",   32'(clk_en_o[3]),  32'(t4_ce[i]));
            chk("t4_stop_busy", 32'(busy_o[3]),    32'(t4_bsy[i]));
        end
        en_i[3] = 1'b1;
        wait_ce(3, 20);
        repeat (3) @(negedge clk_i);
        en_i[3] = 1'b0;
        repeat (2) @(negedge clk_i);
        en_i[3] = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk_i);
            chk("t4_resume_div",  32'(div_clk_o[3]), 32'(t4b_div[i]));
            chk("t4_resume_ce",   32'(clk_en_o[3]),  32'(t4b_ce[i]));
            chk("t4_resume_busy", 32'(busy_o[3]),    32'd1);
        end

        // 5: two requests inside one period of ratio 5, last one wins
        wait_ce(1, 20);
        acks = 0;
        @(negedge clk_i); req(1, 3); acks += int'(upd_ack_o[1]);
        @(negedge clk_i); upd_req_i = '0; acks += int'(upd_ack_o[1]);
        @(negedge clk_i); req(1, 7); acks += int'(upd_ack_o[1]);
        @(negedge clk_i); upd_req_i = '0; acks += int'(upd_ack_o[1]);
        @(negedge clk_i); acks += int'(upd_ack_o[1]);
        chk("t5_ack_at_wrap", 32'(upd_ack_o[1]), 32'd1);
        chk("t5_ack_count", 32'(acks), 32'd1);
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!clk_en_o[1] && n < 20);
        chk("t5_period", 32'(n), 32'd7);

        // 6: async reset mid-period with an update pending
        @(negedge clk_i); req(1, 9);
        @(negedge clk_i); upd_req_i = '0;
        #2 rst_n_i = 1'b0;
        #1 chk("t6_async_zero", 32'({upd_ack_o, div_clk_o, clk_en_o, busy_o}), 32'd0);
        en_i = '0;
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("t6_no_ack", 32'(upd_ack_o), 32'd0);
        end
        en_i[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("t6_rst_ratio", 32'(div_clk_o[1]), (i % 2 == 0) ? 32'd1 : 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
